// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Two-port arbiter in front of a single-outstanding SDRAM
//            controller command port, with periodic auto-refresh scheduling
//            and refresh overrun detection.
// Options  : define SDRAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
//            without it m0 always wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int REF_INTERVAL = 780
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              cmd_valid,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              ref_req,
  input  logic              ref_ack,
  output logic              ref_overrun
);

  localparam int REF_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    REFRESH = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [REF_W-1:0]   ref_cnt;
  logic               ref_pending;
  logic               ref_wrap;
  logic               ref_done;
  logic               take;        // a requester is accepted this cycle
  logic               sel;         // 0 = m0, 1 = m1
  logic               owner;       // requester of the outstanding transaction
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [DATA_W-1:0]  rdata_q;
  logic               rvalid_q;

  assign ref_wrap = (ref_cnt == REF_W'(REF_INTERVAL - 1));
  assign ref_done = (state == REFRESH) && ref_ack;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic last_owner;

  // Tie goes to whichever requester was not served most recently.
  always_comb begin
    sel = ~m0_req;
    if (m0_req && m1_req) sel = ~last_owner;
  end

  // Remember the most recently granted requester.
  always_ff @(posedge clk) begin
    if (reset)     last_owner <= 1'b1;
    else if (take) last_owner <= sel;
  end
`else
  // Fixed priority: m0 wins whenever it is requesting.
  assign sel = ~m0_req;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; refresh pending outranks both requesters in IDLE.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (ref_pending) begin
          state_nxt = REFRESH;
        end else if (m0_req || m1_req) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   if (cmd_ready) state_nxt = lat_we ? IDLE : WAIT_RD;
      WAIT_RD: if (rsp_valid) state_nxt = IDLE;
      REFRESH: if (ref_ack)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Free-running refresh timer; a new wrap wins over a same-cycle ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (ref_wrap)      ref_pending <= 1'b1;
      else if (ref_done) ref_pending <= 1'b0;
    end
  end

  // Capture the winner's command at grant and the read return in WAIT_RD.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (take) begin
        owner     <= sel;
        lat_we    <= sel ? m1_we    : m0_we;
        lat_addr  <= sel ? m1_addr  : m0_addr;
        lat_wdata <= sel ? m1_wdata : m0_wdata;
      end
      if (state == WAIT_RD && rsp_valid) begin
        rdata_q  <= rsp_data;
        rvalid_q <= 1'b1;
      end
    end
  end

  // Every output is forced low while reset is asserted.
  assign m0_gnt      = take & ~sel & ~reset;
  assign m1_gnt      = take &  sel & ~reset;
  assign m0_rvalid   = rvalid_q & ~owner & ~reset;
  assign m1_rvalid   = rvalid_q &  owner & ~reset;
  assign rdata       = reset ? '0 : rdata_q;
  assign cmd_valid   = (state == ISSUE) & ~reset;
  assign cmd_we      = lat_we & ~reset;
  assign cmd_addr    = reset ? '0 : lat_addr;
  assign cmd_wdata   = reset ? '0 : lat_wdata;
  assign ref_req     = (state == REFRESH) & ~reset;
  assign ref_overrun = ref_wrap & ref_pending & ~ref_done & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a
//            transaction-level reference model of sdram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int RI = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] rdata;
  logic          cmd_valid, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          ref_req, ref_ack, ref_overrun;

  int total = 0;
  int bad   = 0;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REF_INTERVAL(RI)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ref_req(ref_req), .ref_ack(ref_ack), .ref_overrun(ref_overrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  int unsigned   ticks;       // clock edges since reset released
  bit            pend;        // refresh owed
  bit            refreshing;  // refresh handshake in progress
  bit            busy;        // a transaction is outstanding
  bit            issued;      // its command has been accepted
  bit            mowner;      // requester of the outstanding transaction
  bit            rv;          // read data is being returned this cycle
  bit            l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, m_rdata;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  bit            mlast;
`endif

  bit            exp_gnt0, exp_gnt1, exp_rv0, exp_rv1, exp_cv, exp_we, exp_rr, exp_ovr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rdata;

  function automatic bit pick();
    if (m0_req && m1_req) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      return !mlast;
`else
      return 1'b0;
`endif
    end
    return !m0_req;
  endfunction

  // Wait for the sampling point and compute the expected outputs.
  task automatic eval();
    bit g, w, wrap;
    @(negedge clk);
    wrap = ((ticks % RI) == RI - 1);
    w    = pick();
    g    = !reset && !busy && !refreshing && !pend && (m0_req || m1_req);
    exp_gnt0  = g && !w;
    exp_gnt1  = g && w;
    exp_cv    = !reset && busy && !issued;
    exp_we    = !reset && l_we;
    exp_addr  = reset ? '0 : l_addr;
    exp_wdata = reset ? '0 : l_wdata;
    exp_rr    = !reset && refreshing;
    exp_ovr   = !reset && wrap && pend && !(refreshing && ref_ack);
    exp_rv0   = !reset && rv && !mowner;
    exp_rv1   = !reset && rv && mowner;
    exp_rdata = reset ? '0 : m_rdata;
  endtask

  // Advance one clock and apply that edge to the model.
  task automatic cycle();
    bit w, wrap, fire;
    @(posedge clk);
    if (reset) begin
      ticks = 0; pend = 0; refreshing = 0; busy = 0; issued = 0;
      mowner = 1; rv = 0; l_we = 0; l_addr = '0; l_wdata = '0; m_rdata = '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      mlast = 1;
`endif
    end else begin
      wrap = ((ticks % RI) == RI - 1);
      fire = refreshing && ref_ack;
      rv   = 0;
      if (!busy && !refreshing) begin
        if (pend) refreshing = 1;
        else if (m0_req || m1_req) begin
          w = pick();
          l_we    = w ? m1_we    : m0_we;
          l_addr  = w ? m1_addr  : m0_addr;
          l_wdata = w ? m1_wdata : m0_wdata;
          busy = 1; issued = 0; mowner = w;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          mlast = w;
`endif
        end
      end else if (refreshing) begin
        if (ref_ack) refreshing = 0;
      end else if (!issued) begin
        if (cmd_ready) begin
          if (l_we) busy = 0;
          else      issued = 1;
        end
      end else if (rsp_valid) begin
        m_rdata = rsp_data; rv = 1; busy = 0;
      end
      if (wrap)      pend = 1;
      else if (fire) pend = 0;
      ticks++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    cmd_ready = 0; rsp_valid = 0; rsp_data = '0; ref_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      m0_req = 1; m1_req = 1'($urandom); m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_addr = AW'($urandom); m1_addr = AW'($urandom);
      cmd_ready = 1'($urandom); rsp_valid = 1; rsp_data = DW'($urandom); ref_ack = 1'($urandom);
      eval();
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, cmd_valid, cmd_we, ref_req, ref_overrun} !== 8'h00) begin
        bad++; $display("FAIL reset_ctrl got=%b exp=00000000",
          {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, cmd_valid, cmd_we, ref_req, ref_overrun});
      end
      total++;
      if (cmd_addr !== '0 || cmd_wdata !== '0 || rdata !== '0) begin
        bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", cmd_addr, cmd_wdata, rdata);
      end
      cycle();
    end
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_write();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 24'h000010; m0_wdata = 16'hBEEF; cmd_ready = 1;
    eval();
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL wr_gnt got=%b exp=10", {m0_gnt, m1_gnt}); end
    cycle();
    m0_req = 0;
    eval();
    total++;
    if ({cmd_valid, cmd_we} !== 2'b11 || cmd_addr !== 24'h000010 || cmd_wdata !== 16'hBEEF) begin
      bad++; $display("FAIL wr_cmd got=%b%b %h %h exp=11 000010 beef", cmd_valid, cmd_we, cmd_addr, cmd_wdata);
    end
    cycle();
    m1_req = 1; m1_we = 1; m1_addr = 24'h000020;
    eval();
    total++;
    if ({cmd_valid, m0_gnt, m1_gnt} !== 3'b001) begin
      bad++; $display("FAIL wr_idle got=%b exp=001", {cmd_valid, m0_gnt, m1_gnt});
    end
    cycle();
    idle_inputs();
  endtask

  task automatic test_read_stall();
    do_reset();
    m1_req = 1; m1_we = 0; m1_addr = 24'h00ABCD; m1_wdata = 16'h5A5A;
    eval();
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL rd_gnt got=%b exp=01", {m0_gnt, m1_gnt}); end
    cycle();
    m1_req = 0; m1_addr = 24'h111111;
    for (int i = 1; i <= 4; i++) begin
      cmd_ready = (i == 4);
      rsp_valid = (i == 2); rsp_data = 16'hDEAD;
      eval();
      total++;
      if ({cmd_valid, cmd_we} !== 2'b10 || cmd_addr !== 24'h00ABCD) begin
        bad++; $display("FAIL rd_hold c%0d got=%b%b %h exp=10 00abcd", i, cmd_valid, cmd_we, cmd_addr);
      end
      cycle();
    end
    cmd_ready = 0; rsp_valid = 0;
    for (int i = 5; i <= 11; i++) begin
      rsp_valid = (i == 10); rsp_data = (i == 10) ? 16'h1234 : 16'hFFFF;
      eval();
      total++;
      if ({m0_rvalid, m1_rvalid} !== ((i == 11) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL rd_rvalid c%0d got=%b exp=%b", i, {m0_rvalid, m1_rvalid}, (i == 11) ? 2'b01 : 2'b00);
      end
      if (i == 11) begin
        total++;
        if (rdata !== 16'h1234) begin bad++; $display("FAIL rd_data got=%h exp=1234", rdata); end
      end
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_tie();
    bit w;
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 24'h0000A0;
    m1_req = 1; m1_we = 1; m1_addr = 24'h0000B1; cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      w = (i % 2) == 1;
`else
      w = 0;
`endif
      eval();
      total++;
      if ({m0_gnt, m1_gnt} !== (w ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL tie_gnt t%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, w ? 2'b01 : 2'b10);
      end
      cycle();
      eval();
      total++;
      if (cmd_valid !== 1'b1 || cmd_addr !== (w ? 24'h0000B1 : 24'h0000A0)) begin
        bad++; $display("FAIL tie_cmd t%0d got=%b %h", i, cmd_valid, cmd_addr);
      end
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_refresh();
    bit any_exp;
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 24'h000300;
    m1_req = 1; m1_we = 1; m1_addr = 24'h000301; cmd_ready = 1;
    for (int i = 0; i < 24; i++) begin
      ref_ack = (i == 19);
      eval();
      any_exp = ((i < 16) || (i >= 20)) && (i % 2 == 0);
      total++;
      if ((m0_gnt | m1_gnt) !== any_exp || ref_req !== (i >= 17 && i <= 19)) begin
        bad++; $display("FAIL ref_seq c%0d got=gnt%b req%b exp=gnt%b req%b", i,
          m0_gnt | m1_gnt, ref_req, any_exp, (i >= 17 && i <= 19));
      end
      total++;
      if ({m0_gnt, m1_gnt} !== {exp_gnt0, exp_gnt1}) begin
        bad++; $display("FAIL ref_win c%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, {exp_gnt0, exp_gnt1});
      end
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_wrap_grant();
    do_reset();
    for (int i = 0; i < 19; i++) begin
      m0_req = (i == 15); m0_we = 1; m0_addr = 24'h000777;
      m1_req = (i == 17); m1_we = 1;
      cmd_ready = 1;
      eval();
      total++;
      if ({m0_gnt, m1_gnt} !== ((i == 15) ? 2'b10 : 2'b00)) begin
        bad++; $display("FAIL wrap_gnt c%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, (i == 15) ? 2'b10 : 2'b00);
      end
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 52; i++) begin
      ref_ack = (i == 50);
      eval();
      total++;
      if (ref_overrun !== (i == 31 || i == 47) || ref_req !== (i >= 17 && i <= 50)) begin
        bad++; $display("FAIL overrun c%0d got=ovr%b req%b exp=ovr%b req%b", i, ref_overrun, ref_req,
          (i == 31 || i == 47), (i >= 17 && i <= 50));
      end
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 24'h000055; cmd_ready = 1;
    eval();
    total++;
    if (m0_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b exp=1", m0_gnt); end
    cycle();
    m0_req = 0;
    eval();
    cycle();
    reset = 1;
    eval();
    total++;
    if ({cmd_valid, m0_rvalid, m1_rvalid, ref_req} !== 4'b0000) begin
      bad++; $display("FAIL mid_rst got=%b exp=0000", {cmd_valid, m0_rvalid, m1_rvalid, ref_req});
    end
    cycle();
    reset = 0; rsp_valid = 1; rsp_data = 16'h5555;
    eval();
    total++;
    if ({cmd_valid, m0_rvalid, m1_rvalid} !== 3'b000) begin
      bad++; $display("FAIL mid_rsp got=%b exp=000", {cmd_valid, m0_rvalid, m1_rvalid});
    end
    cycle();
    rsp_valid = 0; m1_req = 1; m1_we = 1; m1_addr = 24'h000099; m1_wdata = 16'h0099;
    eval();
    total++;
    if ({m0_rvalid, m1_rvalid, m1_gnt} !== 3'b001 || rdata !== 16'h0000) begin
      bad++; $display("FAIL mid_next got=%b rdata=%h exp=001 rdata=0000", {m0_rvalid, m1_rvalid, m1_gnt}, rdata);
    end
    cycle();
    m1_req = 0;
    eval();
    total++;
    if (cmd_valid !== 1'b1 || cmd_addr !== 24'h000099) begin
      bad++; $display("FAIL mid_cmd got=%b %h exp=1 000099", cmd_valid, cmd_addr);
    end
    cycle();
    idle_inputs();
  endtask

  task automatic test_random();
    bit g0, g1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      eval();
      total++;
      if ({m0_gnt, m1_gnt} !== {exp_gnt0, exp_gnt1}) begin
        bad++; $display("FAIL rnd_gnt n%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, {exp_gnt0, exp_gnt1});
      end
      total++;
      if ({m0_rvalid, m1_rvalid} !== {exp_rv0, exp_rv1}) begin
        bad++; $display("FAIL rnd_rvalid n%0d got=%b exp=%b", i, {m0_rvalid, m1_rvalid}, {exp_rv0, exp_rv1});
      end
      total++;
      if (rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata n%0d got=%h exp=%h", i, rdata, exp_rdata); end
      total++;
      if ({cmd_valid, cmd_we} !== {exp_cv, exp_we}) begin
        bad++; $display("FAIL rnd_cmd n%0d got=%b exp=%b", i, {cmd_valid, cmd_we}, {exp_cv, exp_we});
      end
      total++;
      if (cmd_addr !== exp_addr || cmd_wdata !== exp_wdata) begin
        bad++; $display("FAIL rnd_cmddata n%0d got=%h/%h exp=%h/%h", i, cmd_addr, cmd_wdata, exp_addr, exp_wdata);
      end
      total++;
      if ({ref_req, ref_overrun} !== {exp_rr, exp_ovr}) begin
        bad++; $display("FAIL rnd_ref n%0d got=%b exp=%b", i, {ref_req, ref_overrun}, {exp_rr, exp_ovr});
      end
      g0 = exp_gnt0; g1 = exp_gnt1;
      cycle();
      if (g0 || !m0_req) begin
        m0_req = ($urandom_range(0, 2) != 0); m0_we = 1'($urandom);
        m0_addr = AW'($urandom); m0_wdata = DW'($urandom);
      end else if ($urandom_range(0, 19) == 0) m0_req = 0;
      if (g1 || !m1_req) begin
        m1_req = ($urandom_range(0, 2) != 0); m1_we = 1'($urandom);
        m1_addr = AW'($urandom); m1_wdata = DW'($urandom);
      end else if ($urandom_range(0, 19) == 0) m1_req = 0;
      cmd_ready = 1'($urandom);
      rsp_valid = ($urandom_range(0, 2) == 0);
      rsp_data  = DW'($urandom);
      ref_ack   = ($urandom_range(0, 4) < 2);
      reset     = ($urandom_range(0, 99) == 0);
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    cycle();
    test_reset();
    test_write();
    test_read_stall();
    test_tie();
    test_refresh();
    test_wrap_grant();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 Parameter ADDR_W, default 24, SHALL set the SDRAM word-address width.
REQ-003 Parameter DATA_W, default 16, SHALL set the data width and match the 16-bit SDRAM data bus.
REQ-004 Parameter REF_INTERVAL, default 780, SHALL set the clk cycles between refresh requests (7.8 us at 100 MHz).
REQ-005 Port clk, input, 1: system clock.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Ports m0_req and m1_req, input, 1 each: requester n has a transaction pending.
REQ-008 Ports m0_we and m1_we, input, 1 each: 1 = write, 0 = read.
REQ-009 Ports m0_addr and m1_addr, input, ADDR_W each: word address.
REQ-010 Ports m0_wdata and m1_wdata, input, DATA_W each: write data.
REQ-011 Ports m0_gnt and m1_gnt, output, 1 each: one-cycle acceptance pulse.
REQ-012 Ports m0_rvalid and m1_rvalid, output, 1 each: one-cycle read-data-valid pulse.
REQ-013 Port rdata, output, DATA_W: read data shared by both requesters.
REQ-014 Ports cmd_valid, cmd_we, cmd_addr and cmd_wdata, outputs of width 1, 1, ADDR_W and DATA_W: command to the SDRAM controller.
REQ-015 Port cmd_ready, input, 1: the controller accepts the command.
REQ-016 Ports rsp_valid, input, 1, and rsp_data, input, DATA_W: read return from the controller.
REQ-017 Ports ref_req, output, 1, and ref_ack, input, 1: auto-refresh handshake.
REQ-018 Port ref_overrun, output, 1: one-cycle pulse when a refresh interval expires while a refresh is already pending.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT_RD and REFRESH, with at most one transaction outstanding.
REQ-020 In IDLE with ref_pending=1, the FSM SHALL go to REFRESH and grant no requester; refresh has priority over both requesters.
REQ-021 In IDLE with ref_pending=0 and any req high, the block SHALL select one requester and pulse its gnt combinationally in that cycle.
REQ-022 In that same IDLE cycle, the block SHALL latch the selected requester's we, addr and wdata, record it as owner, and go to ISSUE.
REQ-023 In ISSUE, cmd_valid SHALL be 1, with cmd_we, cmd_addr and cmd_wdata held at the latched values until cmd_ready=1.
REQ-024 On cmd_valid and cmd_ready both high, a write SHALL return the FSM to IDLE and a read SHALL move it to WAIT_RD.
REQ-025 In WAIT_RD, on rsp_valid=1 the block SHALL register rsp_data into rdata, pulse the owner's rvalid in the next cycle, and go to IDLE.
REQ-026 rsp_valid SHALL be ignored in any state other than WAIT_RD.
REQ-027 In REFRESH, ref_req SHALL be 1 until ref_ack=1; ref_ack SHALL then clear ref_pending and return the FSM to IDLE.
REQ-028 The refresh counter SHALL count 0 to REF_INTERVAL-1 in every state and wrap to 0, setting ref_pending on the wrap cycle.
REQ-029 If the counter wraps while ref_pending is already 1, ref_overrun SHALL pulse for one cycle and ref_pending SHALL stay 1.
REQ-030 Arbitration decisions SHALL use the registered ref_pending, so a wrap in the same cycle as a request still lets that request be granted.
REQ-031 Requesters SHALL hold req, we, addr and wdata stable until their gnt; a req deasserted before gnt SHALL be dropped silently.
REQ-032 Minimum latency SHALL be: req high in IDLE, then gnt in the same cycle, then cmd_valid in the next cycle.
REQ-033 Minimum read latency SHALL be one cycle from rsp_valid to rvalid.

Reset
REQ-034 Reset SHALL force state=IDLE, ref counter=0, ref_pending=0, and owner and last_owner=1, so m0 wins the first tie.
REQ-035 During reset, all outputs SHALL be 0, including gnt, rvalid, cmd_valid, ref_req and ref_overrun; cmd_addr, cmd_wdata and rdata SHALL be 0.
REQ-036 Reset mid-transaction SHALL abandon the transaction: no rvalid is issued and any later rsp_valid is ignored because the FSM is in IDLE.

Configuration
REQ-037 With macro SDRAM_ARB_ROUND_ROBIN_EN defined, a tie SHALL grant the requester that is not last_owner, and last_owner SHALL update on each gnt.
REQ-038 Without SDRAM_ARB_ROUND_ROBIN_EN, m0 SHALL always win a tie and last_owner SHALL not be implemented.

Verification
REQ-039 Scenario 1: m0 write to addr 0x000010, data 0xBEEF, cmd_ready=1 -> m0_gnt 1 cycle; next cycle cmd_valid=1, cmd_we=1, cmd_addr=0x000010, cmd_wdata=0xBEEF; then IDLE.
REQ-040 Scenario 2: m1 read of 0x00ABCD, cmd_ready stalled 3 cycles, rsp_valid with 0x1234 after 5 cycles -> cmd fields stable through the stall; m1_rvalid=1 with rdata=0x1234 one cycle after rsp_valid; m0_rvalid stays 0.
REQ-041 Scenario 3: with the macro defined, both reqs held high for 4 transactions -> grants m0, m1, m0, m1; without the macro -> m0 every time.
REQ-042 Scenario 4: REF_INTERVAL=16, both reqs high, ref_ack delayed 2 cycles -> ref_req asserts at the first IDLE after the wrap; no gnt while in REFRESH; traffic resumes after ref_ack.
REQ-043 Scenario 5: REF_INTERVAL=16, ref_ack held 0 for 40 cycles -> ref_overrun pulses at the second and third wraps; ref_req stays 1 throughout.
REQ-044 Scenario 6: reset asserted in WAIT_RD, then rsp_valid pulsed -> no rvalid; cmd_valid=0; the next request is granted normally.
